// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states,
// default bus widths and requester IDs.
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DATA_W = 32;

    localparam logic REQ_R0 = 1'b0;   // CPU MEM stage
    localparam logic REQ_R1 = 1'b1;   // loader / debug port

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the memory port of the arbiter.
// slave = arbiter side, master = requesters plus memory.
import dmem_arb_pkg::*;

interface dmem_arbiter_if #(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
);
    logic              r0_req_i;
    logic              r0_we_i;
    logic [ADDR_W-1:0] r0_addr_i;
    logic [DATA_W-1:0] r0_wdata_i;
    logic              r0_gnt_o;
    logic              r0_rvalid_o;
    logic [DATA_W-1:0] r0_rdata_o;

    logic              r1_req_i;
    logic              r1_we_i;
    logic [ADDR_W-1:0] r1_addr_i;
    logic [DATA_W-1:0] r1_wdata_i;
    logic              r1_gnt_o;
    logic              r1_rvalid_o;
    logic [DATA_W-1:0] r1_rdata_o;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              busy_o;

    modport slave (
        input  r0_req_i, r0_we_i, r0_addr_i, r0_wdata_i,
        input  r1_req_i, r1_we_i, r1_addr_i, r1_wdata_i,
        input  mem_rdata_i,
        output r0_gnt_o, r0_rvalid_o, r0_rdata_o,
        output r1_gnt_o, r1_rvalid_o, r1_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output busy_o
    );

    modport master (
        output r0_req_i, r0_we_i, r0_addr_i, r0_wdata_i,
        output r1_req_i, r1_we_i, r1_addr_i, r1_wdata_i,
        output mem_rdata_i,
        input  r0_gnt_o, r0_rvalid_o, r0_rdata_o,
        input  r1_gnt_o, r1_rvalid_o, r1_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  busy_o
    );

endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, on contention the
// requester that was not granted last wins.
import dmem_arb_pkg::*;

module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

    always_comb begin
        winner = REQ_R0;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = REQ_R1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto a single-port data memory with a
// one-cycle read latency; all outputs are registered.
import dmem_arb_pkg::*;

// state  | meaning
// IDLE   | waiting for a request; arbitrates and latches the winner's command
// ISSUE  | command on the memory bus, grant pulse to the winner
// RDWAIT | read data returning from memory, captured for the winner
module dmem_arbiter #(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic           clk_i,
    input  logic           rst_i,
    dmem_arbiter_if.slave  bus
);

    state_e            state_q;
    logic              last_q;
    logic              win_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        req;
    logic              pick;

    assign req = {bus.r1_req_i, bus.r0_req_i};

    rr_arbiter2 u_rr (
        .req    (req),
        .last   (last_q),
        .winner (pick)
    );

    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.busy_o      = (state_q != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            last_q          <= REQ_R1;
            win_q           <= REQ_R0;
            we_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            bus.r0_gnt_o    <= 1'b0;
            bus.r1_gnt_o    <= 1'b0;
            bus.r0_rvalid_o <= 1'b0;
            bus.r1_rvalid_o <= 1'b0;
            bus.r0_rdata_o  <= '0;
            bus.r1_rdata_o  <= '0;
            bus.mem_en_o    <= 1'b0;
            bus.mem_we_o    <= 1'b0;
        end else begin
            // Pulses default low; each state raises only what it owns.
            bus.r0_gnt_o    <= 1'b0;
            bus.r1_gnt_o    <= 1'b0;
            bus.r0_rvalid_o <= 1'b0;
            bus.r1_rvalid_o <= 1'b0;
            bus.mem_en_o    <= 1'b0;
            bus.mem_we_o    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q      <= ISSUE;
                        win_q        <= pick;
                        last_q       <= pick;
                        bus.mem_en_o <= 1'b1;
                        if (pick == REQ_R1) begin
                            bus.r1_gnt_o <= 1'b1;
                            we_q         <= bus.r1_we_i;
                            bus.mem_we_o <= bus.r1_we_i;
                            addr_q       <= bus.r1_addr_i;
                            wdata_q      <= bus.r1_wdata_i;
                        end else begin
                            bus.r0_gnt_o <= 1'b1;
                            we_q         <= bus.r0_we_i;
                            bus.mem_we_o <= bus.r0_we_i;
                            addr_q       <= bus.r0_addr_i;
                            wdata_q      <= bus.r0_wdata_i;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= we_q ? IDLE : RDWAIT;
                end
                RDWAIT: begin
                    state_q <= IDLE;
                    if (win_q == REQ_R1) begin
                        bus.r1_rdata_o  <= bus.mem_rdata_i;
                        bus.r1_rvalid_o <= 1'b1;
                    end else begin
                        bus.r0_rdata_o  <= bus.mem_rdata_i;
                        bus.r0_rvalid_o <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have one clock, clk_i, and a synchronous, active-high reset, rst_i.
REQ-002 Parameter ADDR_W SHALL default to 32 and set the address width.
REQ-003 Parameter DATA_W SHALL default to 32 and set the data width.
REQ-004 clk_i  in  1  clock; all state changes on the rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 rN_req_i  in  1  requester N (N=0 CPU MEM stage, N=1 loader/debug) has a command pending.
REQ-007 rN_we_i  in  1  requester N command is a write (1) or a read (0).
REQ-008 rN_addr_i  in  ADDR_W  requester N word address.
REQ-009 rN_wdata_i  in  DATA_W  requester N write data.
REQ-010 rN_gnt_o  out  1  one-cycle pulse: requester N command accepted.
REQ-011 rN_rvalid_o  out  1  one-cycle pulse: requester N read data valid on rN_rdata_o.
REQ-012 rN_rdata_o  out  DATA_W  registered read data for requester N.
REQ-013 mem_en_o, mem_we_o  out  1 each  memory access enable and write enable.
REQ-014 mem_addr_o  out  ADDR_W  memory address.
REQ-015 mem_wdata_o  out  DATA_W  memory write data.
REQ-016 mem_rdata_i  in  DATA_W  memory read data, valid exactly one cycle after a read-enable cycle.
REQ-017 busy_o  out  1  high whenever the state is not IDLE.

Function
REQ-018 The FSM SHALL have three states:
- IDLE -> ISSUE when any rN_req_i is high.
- ISSUE -> IDLE for a write; ISSUE -> RDWAIT for a read.
- RDWAIT -> IDLE unconditionally.
REQ-019 In IDLE with at least one request, the block SHALL latch the winner's ID, we, addr and wdata on the clock edge.
REQ-020 Arbitration SHALL be 2-way round-robin: a lone requester wins; with both requesting, the winner is the requester not granted last.
REQ-021 In ISSUE the block SHALL assert the winner's rN_gnt_o, assert mem_en_o, drive mem_we_o equal to the latched we, and drive mem_addr_o and mem_wdata_o from the latched command.
REQ-022 Outside ISSUE, mem_en_o and mem_we_o SHALL be 0.
REQ-023 In RDWAIT the block SHALL capture mem_rdata_i into the winner's rN_rdata_o register.
REQ-024 rN_rvalid_o SHALL pulse for one cycle, in the cycle after RDWAIT.
REQ-025 rN_rdata_o SHALL hold its value until that requester's next read completes.
REQ-026 Latency, counted from the cycle in which a request is sampled in IDLE:
- gnt at +1;
- write performed at +1;
- rvalid at +3.
REQ-027 Throughput SHALL be one write per 2 cycles and one read per 3 cycles.
REQ-028 Requesters SHALL hold req, we, addr and wdata stable until they see gnt, and SHALL deassert req (or present a new command) in the cycle after gnt.
REQ-029 The block SHALL ignore rN_req_i in ISSUE and RDWAIT.
REQ-030 If the next request is sampled in the same cycle as an rvalid pulse, the block SHALL accept it (back-to-back operation).
REQ-031 The last-grant pointer SHALL update only on entry to ISSUE.
REQ-032 A requester that keeps requesting while the other is idle SHALL win every arbitration.
REQ-033 Addresses and data SHALL pass to memory unmodified; there is no alignment check.

Reset
REQ-034 On rst_i high at a clock edge, the block SHALL enter IDLE from any state.
REQ-035 Reset SHALL set the last-grant pointer to 1, so r0 wins the first contention.
REQ-036 Reset SHALL clear all gnt and rvalid outputs and both rdata registers.
REQ-037 An operation in flight at reset SHALL be aborted: no rvalid pulse, and mem_en_o low from the cycle after the reset edge.
REQ-038 All outputs SHALL be 0 while rst_i is held high.

Structure
REQ-039 Package dmem_arb_pkg SHALL hold the state enum (IDLE, ISSUE, RDWAIT), the ADDR_W/DATA_W defaults, and the requester-ID constants.
REQ-040 The round-robin pick SHALL be a sub-module rr_arbiter2 (inputs: req[1:0], last; output: winner), purely combinational; the last-grant register lives in dmem_arbiter.

Verification
REQ-041 The bench SHALL cover:
- r0 write, addr 0x10, data 0xDEADBEEF -> r0_gnt_o at +1 with mem_en_o=1, mem_we_o=1 and matching addr/data; busy_o low at +2.
- After that write, r1 read, addr 0x10 -> r1_gnt_o at +1, mem_en_o=1 and mem_we_o=0 at +1; r1_rvalid_o at +3 with r1_rdata_o=0xDEADBEEF; r0_rvalid_o stays 0.
- Both requesters continuously reading, for 4 grants -> grant order after reset r0, r1, r0, r1.
- Reset asserted during RDWAIT -> next cycle IDLE, no rvalid pulse, rdata registers 0.
- Back-to-back r0 writes to 0x0, 0x4, 0x8 -> mem_en_o pulses in alternate cycles, 6 cycles total, values written in order.
